// File: rtl/rob_pkg.sv
// Shared encodings and sizing for the reorder buffer and its lookup ports.
package rob_pkg;
  localparam int ROB_ID_W  = 5;
  localparam int ROB_DEPTH = 1 << ROB_ID_W;
  localparam int ROB_CNT_W = ROB_ID_W + 1;

  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2,
    ROB_TYPE_RSVD   = 2'd3
  } rob_type_e;
endpackage

// File: rtl/rob_query_port.sv
// Operand lookup into the ROB: returns a finished result, bypassing a CDB
// broadcast that targets the same entry in the current cycle.
module rob_query_port
  import rob_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ROB_ID_W-1:0]              query_id,
  input  logic [ROB_DEPTH-1:0]             busy,
  input  logic [ROB_DEPTH-1:0]             ready,
  input  logic [ROB_DEPTH-1:0][XLEN-1:0]   value,
  input  logic                             cdb_valid,
  input  logic [ROB_ID_W-1:0]              cdb_rob_id,
  input  logic [XLEN-1:0]                  cdb_value,
  output logic                             query_ready,
  output logic [XLEN-1:0]                  query_value
);

  // Lookup priority: idle entry, then live CDB bypass, then stored result.
  always_comb begin
    query_ready = 1'b0;
    query_value = {XLEN{1'b0}};
    if (!busy[query_id]) begin
      query_ready = 1'b0;
      query_value = {XLEN{1'b0}};
    end else if (cdb_valid && (cdb_rob_id == query_id)) begin
      query_ready = 1'b1;
      query_value = cdb_value;
    end else if (ready[query_id]) begin
      query_ready = 1'b1;
      query_value = value[query_id];
    end else begin
      query_ready = 1'b0;
      query_value = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// 32-entry circular reorder buffer: allocates ids at issue, captures CDB
// results, retires in order one per cycle and flushes on a mispredicted branch.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                _issue_valid,
  input  logic [1:0]          _issue_type,
  input  logic [4:0]          _issue_rd,
  input  logic [XLEN-1:0]     _issue_pred_pc,
  output logic                _rob_full,
  output logic [4:0]          _rob_free_id,
  output logic                _rob_launch_ready,
  output logic [4:0]          _rob_launch_rob_id,
  output logic [4:0]          _rob_launch_register_id,
  input  logic                _cdb_valid,
  input  logic [4:0]          _cdb_rob_id,
  input  logic [XLEN-1:0]     _cdb_value,
  input  logic [XLEN-1:0]     _cdb_real_pc,
  input  logic [4:0]          _query_rob_id_1,
  input  logic [4:0]          _query_rob_id_2,
  output logic                _query_ready_1,
  output logic                _query_ready_2,
  output logic [XLEN-1:0]     _query_value_1,
  output logic [XLEN-1:0]     _query_value_2,
  output logic                _rob_commit_ready,
  output logic [4:0]          _rob_commit_rob_id,
  output logic [4:0]          _rob_commit_register_id,
  output logic [XLEN-1:0]     _rob_commit_value,
  output logic                _rob_store_commit,
  output logic                _rob_flush,
  output logic [XLEN-1:0]     _rob_flush_pc
);

  localparam logic [ROB_CNT_W-1:0] FULL_CNT = ROB_CNT_W'(ROB_DEPTH);
  localparam logic [ROB_ID_W-1:0]  ID_ZERO  = {ROB_ID_W{1'b0}};

  logic [ROB_ID_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [ROB_CNT_W-1:0]            count_q, count_d;
  logic [ROB_DEPTH-1:0]            busy_q, busy_d, ready_q, ready_d;
  rob_type_e [ROB_DEPTH-1:0]       type_q, type_d;
  logic [ROB_DEPTH-1:0][4:0]       rd_q, rd_d;
  logic [ROB_DEPTH-1:0][XLEN-1:0]  value_q, value_d;
  logic [ROB_DEPTH-1:0][XLEN-1:0]  pred_pc_q, pred_pc_d, real_pc_q, real_pc_d;

  logic                commit_ready_q, commit_ready_d;
  logic [ROB_ID_W-1:0] commit_rob_id_q, commit_rob_id_d;
  logic [4:0]          commit_reg_q, commit_reg_d;
  logic [XLEN-1:0]     commit_value_q, commit_value_d;
  logic                store_commit_q, store_commit_d;
  logic                flush_q, flush_d;
  logic [XLEN-1:0]     flush_pc_q, flush_pc_d;

  logic                 head_fire, mispredict, accept, cdb_hit;
  rob_type_e            head_type, issue_type;
  logic [ROB_DEPTH-1:0] issue_we, commit_we, cdb_we;

  assign issue_type = rob_type_e'(_issue_type);
  assign head_type  = type_q[head_q];
  // Head readiness is taken from state only, so a same-cycle CDB write retires next cycle.
  assign head_fire  = rdy_in & busy_q[head_q] & ready_q[head_q];
  assign mispredict = head_fire & (head_type == ROB_TYPE_BRANCH) &
                      (real_pc_q[head_q] != pred_pc_q[head_q]);
  assign _rob_full  = (count_q == FULL_CNT);
  assign accept     = rdy_in & _issue_valid & ~_rob_full & ~mispredict;
  assign cdb_hit    = rdy_in & _cdb_valid & busy_q[_cdb_rob_id];

  assign issue_we   = accept    ? (ROB_DEPTH'(1) << tail_q)      : {ROB_DEPTH{1'b0}};
  assign commit_we  = head_fire ? (ROB_DEPTH'(1) << head_q)      : {ROB_DEPTH{1'b0}};
  assign cdb_we     = cdb_hit   ? (ROB_DEPTH'(1) << _cdb_rob_id) : {ROB_DEPTH{1'b0}};

  assign _rob_free_id            = tail_q;
  assign _rob_launch_ready       = accept & (_issue_rd != 5'd0) & (issue_type != ROB_TYPE_STORE);
  assign _rob_launch_rob_id      = tail_q;
  assign _rob_launch_register_id = _issue_rd;

  assign _rob_commit_ready       = commit_ready_q;
  assign _rob_commit_rob_id      = commit_rob_id_q;
  assign _rob_commit_register_id = commit_reg_q;
  assign _rob_commit_value       = commit_value_q;
  assign _rob_store_commit       = store_commit_q;
  assign _rob_flush              = flush_q;
  assign _rob_flush_pc           = flush_pc_q;

  // Per-entry next state: flush clears all, else issue / retire / CDB capture.
  always_comb begin
    busy_d    = busy_q;
    ready_d   = ready_q;
    type_d    = type_q;
    rd_d      = rd_q;
    value_d   = value_q;
    pred_pc_d = pred_pc_q;
    real_pc_d = real_pc_q;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (mispredict) begin
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end else if (issue_we[i]) begin
        busy_d[i]  = 1'b1;
        ready_d[i] = 1'b0;
      end else if (commit_we[i]) begin
        busy_d[i]  = 1'b0;
        ready_d[i] = 1'b0;
      end else if (cdb_we[i]) begin
        busy_d[i]  = busy_q[i];
        ready_d[i] = 1'b1;
      end else begin
        busy_d[i]  = busy_q[i];
        ready_d[i] = ready_q[i];
      end

      if (issue_we[i]) begin
        type_d[i]    = issue_type;
        rd_d[i]      = _issue_rd;
        pred_pc_d[i] = _issue_pred_pc;
        value_d[i]   = {XLEN{1'b0}};
        real_pc_d[i] = {XLEN{1'b0}};
      end else if (cdb_we[i]) begin
        value_d[i]   = _cdb_value;
        real_pc_d[i] = _cdb_real_pc;
      end else begin
        value_d[i]   = value_q[i];
        real_pc_d[i] = real_pc_q[i];
      end
    end
  end

  // Pointers, occupancy and the registered retire/flush outputs.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispredict) begin
      head_d  = ID_ZERO;
      tail_d  = ID_ZERO;
      count_d = {ROB_CNT_W{1'b0}};
    end else begin
      head_d  = head_q + ROB_ID_W'(head_fire);
      tail_d  = tail_q + ROB_ID_W'(accept);
      count_d = count_q + ROB_CNT_W'(accept) - ROB_CNT_W'(head_fire);
    end

    commit_ready_d  = head_fire;
    commit_rob_id_d = head_fire ? head_q : ID_ZERO;
    commit_reg_d    = (head_fire && (head_type != ROB_TYPE_STORE)) ? rd_q[head_q] : 5'd0;
    commit_value_d  = head_fire ? value_q[head_q] : {XLEN{1'b0}};
    store_commit_d  = head_fire & (head_type == ROB_TYPE_STORE);
    flush_d         = mispredict;
    flush_pc_d      = mispredict ? real_pc_q[head_q] : {XLEN{1'b0}};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head_q          <= ID_ZERO;
      tail_q          <= ID_ZERO;
      count_q         <= {ROB_CNT_W{1'b0}};
      busy_q          <= {ROB_DEPTH{1'b0}};
      ready_q         <= {ROB_DEPTH{1'b0}};
      type_q          <= {ROB_DEPTH{ROB_TYPE_REG}};
      rd_q            <= '{default: 5'd0};
      value_q         <= '{default: {XLEN{1'b0}}};
      pred_pc_q       <= '{default: {XLEN{1'b0}}};
      real_pc_q       <= '{default: {XLEN{1'b0}}};
      commit_ready_q  <= 1'b0;
      commit_rob_id_q <= ID_ZERO;
      commit_reg_q    <= 5'd0;
      commit_value_q  <= {XLEN{1'b0}};
      store_commit_q  <= 1'b0;
      flush_q         <= 1'b0;
      flush_pc_q      <= {XLEN{1'b0}};
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      busy_q          <= busy_d;
      ready_q         <= ready_d;
      type_q          <= type_d;
      rd_q            <= rd_d;
      value_q         <= value_d;
      pred_pc_q       <= pred_pc_d;
      real_pc_q       <= real_pc_d;
      commit_ready_q  <= commit_ready_d;
      commit_rob_id_q <= commit_rob_id_d;
      commit_reg_q    <= commit_reg_d;
      commit_value_q  <= commit_value_d;
      store_commit_q  <= store_commit_d;
      flush_q         <= flush_d;
      flush_pc_q      <= flush_pc_d;
    end
  end

  rob_query_port #(.XLEN(XLEN)) u_query_1 (
    .query_id    (_query_rob_id_1),
    .busy        (busy_q),
    .ready       (ready_q),
    .value       (value_q),
    .cdb_valid   (_cdb_valid),
    .cdb_rob_id  (_cdb_rob_id),
    .cdb_value   (_cdb_value),
    .query_ready (_query_ready_1),
    .query_value (_query_value_1)
  );

  rob_query_port #(.XLEN(XLEN)) u_query_2 (
    .query_id    (_query_rob_id_2),
    .busy        (busy_q),
    .ready       (ready_q),
    .value       (value_q),
    .cdb_valid   (_cdb_valid),
    .cdb_rob_id  (_cdb_rob_id),
    .cdb_value   (_cdb_value),
    .query_ready (_query_ready_2),
    .query_value (_query_value_2)
  );

endmodule
